vx_gpr_wnd_stage: RTL and testbench
===================================

VX_GPR_WND_STAGE -- requirements
Module: VX_gpr_wnd_stage

Interface
REQ-001 SHALL have parameters, one per line:
- NUM_THREADS, 4, lanes per warp
- NUM_WARPS, 4, warps
- NUM_RPORTS, 3, read ports per request (2..3)
- GLOBAL_REGS, 8, non-windowed regs r0..GLOBAL_REGS-1
- NUM_WINDOWS, 4, register windows per warp
- (fixed) NUM_REGS = 32; WND_REGS = NUM_REGS - GLOBAL_REGS; DATAW = 32
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  clock; one clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- wb_valid  in  1  writeback valid
- wb_wid  in  log2(NUM_WARPS)  writeback warp
- wb_rd  in  5  destination reg
- wb_tmask  in  NUM_THREADS  lane write mask
- wb_data  in  NUM_THREADS*32  lane data
- wb_ready  out  1  writeback ready
- req_valid  in  1  read request valid
- req_wid  in  log2(NUM_WARPS)  read warp
- req_rs  in  NUM_RPORTS*5  source regs, port p at bits [5p+4:5p]
- req_ready  out  1  read request accepted
- rsp_valid  out  1  read response valid
- rsp_data  out  NUM_RPORTS*NUM_THREADS*32  per port, per lane data
- rsp_ready  in  1  consumer ready
- wnd_valid  in  1  window op valid
- wnd_wid  in  log2(NUM_WARPS)  window op warp
- wnd_op  in  1  0=SAVE, 1=RESTORE
- wnd_ready  out  1  window op ready (constant 1)
- wnd_fault  out  1  one-cycle pulse: op rejected (overflow/underflow)
- wnd_fault_wid  out  log2(NUM_WARPS)  faulting warp

Function
REQ-003 Per warp SHALL keep cwp (0..NUM_WINDOWS-1, wraps) and depth (0..NUM_WINDOWS-1).
REQ-004 Physical index SHALL be wid*(GLOBAL_REGS+NUM_WINDOWS*WND_REGS) + r for r<GLOBAL_REGS, else + GLOBAL_REGS + cwp[wid]*WND_REGS + (r-GLOBAL_REGS).
REQ-005 SAVE with depth<NUM_WINDOWS-1 SHALL set cwp=(cwp+1) mod NUM_WINDOWS, depth+=1; else no state change, wnd_fault=1 next cycle.
REQ-006 RESTORE with depth>0 SHALL set cwp=(cwp-1) mod NUM_WINDOWS, depth-=1; else no state change, wnd_fault=1 next cycle.
REQ-007 Window update SHALL take effect on the accepting edge; read/write address translation in that same cycle SHALL use the pre-update cwp.
REQ-008 Lane i SHALL be written when wb_valid && wb_tmask[i] && wb_rd!=0; wb_ready SHALL be constant 1.
REQ-009 Reads of r0 SHALL return 0 on every lane regardless of RAM contents.
REQ-010 Read accepted on req_valid && req_ready; req_ready = !rsp_valid || rsp_ready; rsp_valid SHALL assert exactly 1 cycle after acceptance.
REQ-011 rsp_data SHALL hold stable while rsp_valid && !rsp_ready, unaffected by later writes.
REQ-012 rsp_valid SHALL deassert after the handshake cycle unless a new request is accepted in the same cycle (back-to-back, full throughput).
REQ-013 Same-cycle write and read of the same physical index SHALL return old data (without REQ-020).

Reset
REQ-014 On reset low: cwp=0, depth=0 for all warps; rsp_valid=0; wnd_fault=0; wnd_fault_wid=0; rsp_data=0.
REQ-015 Reset SHALL be asserted asynchronously and released synchronously to clk; an in-flight response SHALL be dropped.
REQ-016 RAM contents SHALL NOT be cleared by reset; power-up init to 0.
REQ-017 Window op coincident with reset release edge SHALL be ignored.

Configuration
REQ-018 Exactly one macro: VX_GPR_BYPASS_EN.
REQ-019 Without it: behaviour per REQ-013.
REQ-020 With it: lane whose same-cycle write hits a read's physical index (rd!=0, tmask set) SHALL return wb_data for that lane; other lanes old data.

Verification
REQ-021 Write w1 r5 all lanes 0x11111111, read w1 r5 next cycle -> rsp_valid 1 cycle later, all lanes 0x11111111.
REQ-022 Write w0 r10=0xA (cwp0), SAVE w0, write r10=0xB, RESTORE w0, read r10 -> 0xA; r3 written before SAVE reads identical across windows.
REQ-023 Four SAVEs on w2 (NUM_WINDOWS=4) -> 4th pulses wnd_fault=1, wnd_fault_wid=2, cwp stays 3; RESTORE at depth 0 -> fault.
REQ-024 Write r0=0xFFFFFFFF then read r0 -> 0; tmask=0b0101 write -> lanes 1,3 unchanged.
REQ-025 rsp_ready=0 for 3 cycles while writing same reg -> rsp_data stable, req_ready=0; then back-to-back reads every cycle with rsp_ready=1.
REQ-026 Same-cycle write/read w3 r7 0x55 over 0x22 -> 0x22 without macro, 0x55 with VX_GPR_BYPASS_EN; reset mid-response -> rsp_valid 0, cwp 0.

Source files
------------

// File: rtl/vx_gpr_wnd_stage.sv
// Windowed GPR file for a SIMT core: per-warp register windows, one writeback port, NUM_RPORTS registered read ports.
// Optional macro VX_GPR_BYPASS_EN forwards a same-cycle writeback into the read response.
module vx_gpr_wnd_stage #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_WARPS   = 4,
  parameter int NUM_RPORTS  = 3,
  parameter int GLOBAL_REGS = 8,
  parameter int NUM_WINDOWS = 4,
  localparam int WIDW       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 wb_valid,
  input  logic [WIDW-1:0]                      wb_wid,
  input  logic [4:0]                           wb_rd,
  input  logic [NUM_THREADS-1:0]               wb_tmask,
  input  logic [NUM_THREADS*32-1:0]            wb_data,
  output logic                                 wb_ready,
  input  logic                                 req_valid,
  input  logic [WIDW-1:0]                      req_wid,
  input  logic [NUM_RPORTS*5-1:0]              req_rs,
  output logic                                 req_ready,
  output logic                                 rsp_valid,
  output logic [NUM_RPORTS*NUM_THREADS*32-1:0] rsp_data,
  input  logic                                 rsp_ready,
  input  logic                                 wnd_valid,
  input  logic [WIDW-1:0]                      wnd_wid,
  input  logic                                 wnd_op,
  output logic                                 wnd_ready,
  output logic                                 wnd_fault,
  output logic [WIDW-1:0]                      wnd_fault_wid
);

  localparam int NUM_REGS  = 32;
  localparam int WND_REGS  = NUM_REGS - GLOBAL_REGS;
  localparam int DATAW     = 32;
  localparam int WARP_REGS = GLOBAL_REGS + NUM_WINDOWS * WND_REGS;
  localparam int RAM_DEPTH = NUM_WARPS * WARP_REGS;
  localparam int AW        = $clog2(RAM_DEPTH);
  localparam int CWPW      = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
  localparam int LANEW     = NUM_THREADS * DATAW;

  logic [CWPW-1:0]  cwp   [NUM_WARPS];
  logic [CWPW-1:0]  depth [NUM_WARPS];
  logic             rst_done;

  logic             wnd_go;
  logic [CWPW-1:0]  wnd_cur_cwp;
  logic [CWPW-1:0]  wnd_cur_depth;
  logic [CWPW-1:0]  cwp_inc;
  logic [CWPW-1:0]  cwp_dec;
  logic             save_ok;
  logic             restore_ok;
  logic             wnd_err;

  logic [DATAW-1:0] mem [NUM_THREADS][RAM_DEPTH];
  logic [AW-1:0]    wb_addr;
  logic             wb_en;

  logic [4:0]       rd_reg  [NUM_RPORTS];
  logic [AW-1:0]    rd_addr [NUM_RPORTS];
  logic [DATAW-1:0] rd_lane;
  logic [NUM_RPORTS*LANEW-1:0] rd_data;
  logic             accept;

  function automatic logic [AW-1:0] phys_addr(input logic [WIDW-1:0] wid,
                                              input logic [4:0]      r,
                                              input logic [CWPW-1:0] wcwp);
    int idx;
    idx = int'(wid) * WARP_REGS;
    if (int'(r) < GLOBAL_REGS)
      idx = idx + int'(r);
    else
      idx = idx + GLOBAL_REGS + int'(wcwp) * WND_REGS + (int'(r) - GLOBAL_REGS);
    return AW'(idx);
  endfunction

  assign wb_ready  = 1'b1;
  assign wnd_ready = 1'b1;

  // Window ops are ignored on the edge that releases reset.
  assign wnd_go        = wnd_valid && rst_done;
  assign wnd_cur_cwp   = cwp[wnd_wid];
  assign wnd_cur_depth = depth[wnd_wid];
  assign cwp_inc       = (wnd_cur_cwp == CWPW'(NUM_WINDOWS - 1)) ? '0 : wnd_cur_cwp + CWPW'(1);
  assign cwp_dec       = (wnd_cur_cwp == '0) ? CWPW'(NUM_WINDOWS - 1) : wnd_cur_cwp - CWPW'(1);
  assign save_ok       = !wnd_op && (int'(wnd_cur_depth) < NUM_WINDOWS - 1);
  assign restore_ok    = wnd_op && (wnd_cur_depth != '0);
  assign wnd_err       = wnd_go && !save_ok && !restore_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        cwp[w]   <= '0;
        depth[w] <= '0;
      end
      rst_done      <= 1'b0;
      wnd_fault     <= 1'b0;
      wnd_fault_wid <= '0;
    end else begin
      rst_done  <= 1'b1;
      wnd_fault <= wnd_err;
      if (wnd_err)
        wnd_fault_wid <= wnd_wid;
      if (wnd_go && save_ok) begin
        cwp[wnd_wid]   <= cwp_inc;
        depth[wnd_wid] <= wnd_cur_depth + CWPW'(1);
      end else if (wnd_go && restore_ok) begin
        cwp[wnd_wid]   <= cwp_dec;
        depth[wnd_wid] <= wnd_cur_depth - CWPW'(1);
      end
    end
  end

  // Register contents survive reset; only the pipeline/window state is cleared.
  assign wb_addr = phys_addr(wb_wid, wb_rd, cwp[wb_wid]);
  assign wb_en   = wb_valid && (wb_rd != 5'd0);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (wb_en && wb_tmask[i])
        mem[i][wb_addr] <= wb_data[i*DATAW +: DATAW];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_lane = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      rd_reg[p]  = req_rs[p*5 +: 5];
      rd_addr[p] = phys_addr(req_wid, rd_reg[p], cwp[req_wid]);
      for (int i = 0; i < NUM_THREADS; i++) begin
        rd_lane = mem[i][rd_addr[p]];
`ifdef VX_GPR_BYPASS_EN
        if (wb_en && wb_tmask[i] && (wb_addr == rd_addr[p]))
          rd_lane = wb_data[i*DATAW +: DATAW];
`endif
        if (rd_reg[p] == 5'd0)
          rd_lane = '0;
        rd_data[(p*NUM_THREADS + i)*DATAW +: DATAW] = rd_lane;
      end
    end
  end

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  // Response register doubles as the skid stage: it only loads on a new accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= accept || (rsp_valid && !rsp_ready);
      if (accept)
        rsp_data <= rd_data;
    end
  end

endmodule

// File: tb/tb_vx_gpr_wnd_stage.sv
// Directed self-checking bench for vx_gpr_wnd_stage; read responses are checked through a scoreboard queue.
// Expected same-cycle read/write results follow VX_GPR_BYPASS_EN.
module tb_vx_gpr_wnd_stage;

  localparam int NUM_THREADS = 4;
  localparam int NUM_WARPS   = 4;
  localparam int NUM_RPORTS  = 3;
  localparam int GLOBAL_REGS = 8;
  localparam int NUM_WINDOWS = 4;
  localparam int LANEW       = NUM_THREADS * 32;
  localparam int RSPW        = NUM_RPORTS * LANEW;

  logic             clk = 1'b0;
  logic             reset;
  logic             wb_valid;
  logic [1:0]       wb_wid;
  logic [4:0]       wb_rd;
  logic [3:0]       wb_tmask;
  logic [LANEW-1:0] wb_data;
  logic             wb_ready;
  logic             req_valid;
  logic [1:0]       req_wid;
  logic [14:0]      req_rs;
  logic             req_ready;
  logic             rsp_valid;
  logic [RSPW-1:0]  rsp_data;
  logic             rsp_ready;
  logic             wnd_valid;
  logic [1:0]       wnd_wid;
  logic             wnd_op;
  logic             wnd_ready;
  logic             wnd_fault;
  logic [1:0]       wnd_fault_wid;

  int vectors = 0;
  int miscompares = 0;
  logic [RSPW-1:0] sb_q [$];

  vx_gpr_wnd_stage #(
    .NUM_THREADS (NUM_THREADS),
    .NUM_WARPS   (NUM_WARPS),
    .NUM_RPORTS  (NUM_RPORTS),
    .GLOBAL_REGS (GLOBAL_REGS),
    .NUM_WINDOWS (NUM_WINDOWS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_wid        (wb_wid),
    .wb_rd         (wb_rd),
    .wb_tmask      (wb_tmask),
    .wb_data       (wb_data),
    .wb_ready      (wb_ready),
    .req_valid     (req_valid),
    .req_wid       (req_wid),
    .req_rs        (req_rs),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_ready     (rsp_ready),
    .wnd_valid     (wnd_valid),
    .wnd_wid       (wnd_wid),
    .wnd_op        (wnd_op),
    .wnd_ready     (wnd_ready),
    .wnd_fault     (wnd_fault),
    .wnd_fault_wid (wnd_fault_wid)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [RSPW-1:0] observed,
                              input logic [RSPW-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [LANEW-1:0] all_lanes(input logic [31:0] v);
    return {NUM_THREADS{v}};
  endfunction

  function automatic logic [RSPW-1:0] rsp3(input logic [LANEW-1:0] p0, input logic [LANEW-1:0] p1,
                                           input logic [LANEW-1:0] p2);
    return {p2, p1, p0};
  endfunction

  function automatic logic [14:0] rs3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return {c, b, a};
  endfunction

  // Every handshaken response is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb_q.size() == 0)
        check_output("sb_pending", RSPW'(sb_q.size()), RSPW'(1));
      else
        check_output("rsp_data", rsp_data, sb_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_write(input logic [1:0] wid, input logic [4:0] rd, input logic [3:0] mask,
                             input logic [LANEW-1:0] data);
    wb_valid = 1'b1;
    wb_wid   = wid;
    wb_rd    = rd;
    wb_tmask = mask;
    wb_data  = data;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic apply_read(input string tag, input logic [1:0] wid, input logic [14:0] rs,
                            input logic [RSPW-1:0] expected);
    check_output({tag, "_req_ready"}, RSPW'(req_ready), RSPW'(1));
    req_valid = 1'b1;
    req_wid   = wid;
    req_rs    = rs;
    sb_q.push_back(expected);
    tick();
    req_valid = 1'b0;
    check_output({tag, "_rsp_valid"}, RSPW'(rsp_valid), RSPW'(1));
  endtask

  task automatic apply_wnd(input string tag, input logic [1:0] wid, input logic op, input logic exp_fault);
    wnd_valid = 1'b1;
    wnd_wid   = wid;
    wnd_op    = op;
    tick();
    wnd_valid = 1'b0;
    check_output({tag, "_fault"}, RSPW'(wnd_fault), RSPW'(exp_fault));
    if (exp_fault)
      check_output({tag, "_fault_wid"}, RSPW'(wnd_fault_wid), RSPW'(wid));
  endtask

  initial begin
    logic [LANEW-1:0] masked;
    logic [LANEW-1:0] same_cycle;
    logic [RSPW-1:0]  held;

    reset     = 1'b0;
    wb_valid  = 1'b0;
    wb_wid    = '0;
    wb_rd     = '0;
    wb_tmask  = '0;
    wb_data   = '0;
    req_valid = 1'b0;
    req_wid   = '0;
    req_rs    = '0;
    rsp_ready = 1'b1;
    wnd_valid = 1'b0;
    wnd_wid   = '0;
    wnd_op    = 1'b0;
    masked    = {32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA, 32'h55555555};

    repeat (3) tick();
    check_output("rst_rsp_valid", RSPW'(rsp_valid), RSPW'(0));
    check_output("rst_rsp_data", rsp_data, '0);
    check_output("rst_wnd_fault", RSPW'(wnd_fault), RSPW'(0));
    check_output("rst_fault_wid", RSPW'(wnd_fault_wid), RSPW'(0));
    check_output("wb_ready", RSPW'(wb_ready), RSPW'(1));
    check_output("wnd_ready", RSPW'(wnd_ready), RSPW'(1));
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();

    // Basic write then read, response one cycle after acceptance.
    apply_write(2'd1, 5'd5, 4'hF, all_lanes(32'h11111111));
    apply_read("t1", 2'd1, rs3(5'd5, 5'd0, 5'd0), rsp3(all_lanes(32'h11111111), '0, '0));
    tick();
    check_output("t1_rsp_drop", RSPW'(rsp_valid), RSPW'(0));

    // Windowed vs global registers across SAVE/RESTORE.
    apply_write(2'd0, 5'd10, 4'hF, all_lanes(32'hA));
    apply_write(2'd0, 5'd3, 4'hF, all_lanes(32'h3333));
    apply_wnd("save0", 2'd0, 1'b0, 1'b0);
    apply_write(2'd0, 5'd10, 4'hF, all_lanes(32'hB));
    apply_read("t2a", 2'd0, rs3(5'd10, 5'd3, 5'd0), rsp3(all_lanes(32'hB), all_lanes(32'h3333), '0));
    apply_wnd("rest0", 2'd0, 1'b1, 1'b0);
    apply_read("t2b", 2'd0, rs3(5'd10, 5'd3, 5'd0), rsp3(all_lanes(32'hA), all_lanes(32'h3333), '0));

    // Overflow and underflow on warp 2, then underflow on warp 1.
    apply_write(2'd2, 5'd9, 4'hF, all_lanes(32'h90));
    for (int k = 0; k < 3; k++)
      apply_wnd("save2", 2'd2, 1'b0, 1'b0);
    apply_write(2'd2, 5'd9, 4'hF, all_lanes(32'h93));
    apply_wnd("save2_ovf", 2'd2, 1'b0, 1'b1);
    tick();
    check_output("save2_pulse", RSPW'(wnd_fault), RSPW'(0));
    apply_read("t3a", 2'd2, rs3(5'd9, 5'd0, 5'd0), rsp3(all_lanes(32'h93), '0, '0));
    for (int k = 0; k < 3; k++)
      apply_wnd("rest2", 2'd2, 1'b1, 1'b0);
    apply_read("t3b", 2'd2, rs3(5'd9, 5'd0, 5'd0), rsp3(all_lanes(32'h90), '0, '0));
    apply_wnd("rest2_unf", 2'd2, 1'b1, 1'b1);
    apply_wnd("rest1_unf", 2'd1, 1'b1, 1'b1);
    tick();
    check_output("rest1_pulse", RSPW'(wnd_fault), RSPW'(0));

    // r0 is hardwired to zero; masked lanes keep old data.
    apply_write(2'd0, 5'd0, 4'hF, all_lanes(32'hFFFFFFFF));
    apply_read("t4a", 2'd0, rs3(5'd0, 5'd0, 5'd0), '0);
    apply_write(2'd1, 5'd6, 4'hF, all_lanes(32'hAAAAAAAA));
    apply_write(2'd1, 5'd6, 4'b0101, all_lanes(32'h55555555));
    apply_read("t4b", 2'd1, rs3(5'd6, 5'd0, 5'd0), rsp3(masked, '0, '0));

    // Stall: response holds through a write to the same register, new request is blocked.
    tick();
    rsp_ready = 1'b0;
    held = rsp3(all_lanes(32'h11111111), masked, '0);
    apply_read("t5", 2'd1, rs3(5'd5, 5'd6, 5'd0), held);
    req_valid = 1'b1;
    req_wid   = 2'd1;
    req_rs    = rs3(5'd5, 5'd0, 5'd0);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        wb_valid = 1'b1;
        wb_wid   = 2'd1;
        wb_rd    = 5'd5;
        wb_tmask = 4'hF;
        wb_data  = all_lanes(32'h77777777);
      end
      tick();
      wb_valid = 1'b0;
      check_output("t5_hold_data", rsp_data, held);
      check_output("t5_hold_valid", RSPW'(rsp_valid), RSPW'(1));
      check_output("t5_req_ready", RSPW'(req_ready), RSPW'(0));
    end

    // Back-to-back reads at full throughput.
    rsp_ready = 1'b1;
    sb_q.push_back(rsp3(all_lanes(32'h77777777), '0, '0));
    tick();
    check_output("b2b0_valid", RSPW'(rsp_valid), RSPW'(1));
    check_output("b2b0_ready", RSPW'(req_ready), RSPW'(1));
    req_wid = 2'd0;
    req_rs  = rs3(5'd10, 5'd0, 5'd0);
    sb_q.push_back(rsp3(all_lanes(32'hA), '0, '0));
    tick();
    check_output("b2b1_valid", RSPW'(rsp_valid), RSPW'(1));
    req_wid = 2'd2;
    req_rs  = rs3(5'd9, 5'd0, 5'd0);
    sb_q.push_back(rsp3(all_lanes(32'h90), '0, '0));
    tick();
    check_output("b2b2_valid", RSPW'(rsp_valid), RSPW'(1));
    req_valid = 1'b0;
    tick();
    check_output("b2b_drop", RSPW'(rsp_valid), RSPW'(0));

    // Same-cycle write and read of w3 r7, lanes 0..1 written.
    apply_write(2'd3, 5'd7, 4'hF, all_lanes(32'h22));
`ifdef VX_GPR_BYPASS_EN
    same_cycle = {32'h22, 32'h22, 32'h55, 32'h55};
`else
    same_cycle = all_lanes(32'h22);
`endif
    wb_valid  = 1'b1;
    wb_wid    = 2'd3;
    wb_rd     = 5'd7;
    wb_tmask  = 4'b0011;
    wb_data   = all_lanes(32'h55);
    req_valid = 1'b1;
    req_wid   = 2'd3;
    req_rs    = rs3(5'd7, 5'd0, 5'd0);
    sb_q.push_back(rsp3(same_cycle, '0, '0));
    tick();
    wb_valid  = 1'b0;
    req_valid = 1'b0;
    check_output("t6a_rsp_valid", RSPW'(rsp_valid), RSPW'(1));
    apply_read("t6b", 2'd3, rs3(5'd7, 5'd0, 5'd0), rsp3({32'h22, 32'h22, 32'h55, 32'h55}, '0, '0));

    // Reset while a response is stalled; window op on the release edge is ignored.
    apply_wnd("save0b", 2'd0, 1'b0, 1'b0);
    tick();
    rsp_ready = 1'b0;
    apply_read("t7", 2'd0, rs3(5'd10, 5'd0, 5'd0), rsp3(all_lanes(32'hB), '0, '0));
    check_output("t7_pre_data", rsp_data, rsp3(all_lanes(32'hB), '0, '0));
    #2;
    reset = 1'b0;
    #1;
    check_output("t7_rst_valid", RSPW'(rsp_valid), RSPW'(0));
    check_output("t7_rst_data", rsp_data, '0);
    sb_q.delete();
    rsp_ready = 1'b1;
    @(posedge clk);
    wnd_valid = 1'b1;
    wnd_wid   = 2'd0;
    wnd_op    = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    wnd_valid = 1'b0;
    check_output("t7_release_fault", RSPW'(wnd_fault), RSPW'(0));
    tick();
    apply_read("t7_after", 2'd0, rs3(5'd10, 5'd0, 5'd0), rsp3(all_lanes(32'hA), '0, '0));
    apply_wnd("t7_depth0", 2'd0, 1'b1, 1'b1);
    tick();
    check_output("sb_drained", RSPW'(sb_q.size()), RSPW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
